pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and
// I/D memory miss sequencing, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             ex_memread_i,
    input  logic             branch_taken_i,
    input  logic             imem_miss_i,
    input  logic             dmem_miss_i,
    input  logic             imem_ack_i,
    input  logic             dmem_ack_i,
    input  logic             clr_cnt_i,
    output logic             pc_enable_o,
    output logic             ifid_hold_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_hold_o,
    output logic             imem_req_o,
    output logic             dmem_req_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IWAIT = 2'd1,
        DWAIT = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             lu_hz;
    logic             pc_en;
    logic             ifid_hold;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_hold;
    logic             imem_req;
    logic             dmem_req;
    logic [CNT_W-1:0] cnt;

    assign lu_hz = ex_memread_i & (ex_rt_i != '0) &
                   ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        pc_en       = 1'b1;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_hold  = 1'b0;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        unique case (state)
            RUN: begin
                if (dmem_miss_i) begin
                    pc_en      = 1'b0;
                    ifid_hold  = 1'b1;
                    exmem_hold = 1'b1;
                    next_state = DWAIT;
                end else if (lu_hz) begin
                    pc_en       = 1'b0;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                end else if (branch_taken_i) begin
                    // a taken branch redirects fetch, so a concurrent I-miss is moot
                    ifid_flush = 1'b1;
                end else if (imem_miss_i) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                    next_state = IWAIT;
                end
            end
            IWAIT: begin
                imem_req   = 1'b1;
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
                exmem_hold = dmem_miss_i;
                if (imem_ack_i) begin
                    next_state = DRAIN;
                end
            end
            DWAIT: begin
                dmem_req   = 1'b1;
                pc_en      = 1'b0;
                ifid_hold  = 1'b1;
                exmem_hold = 1'b1;
                if (dmem_ack_i) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                // a D-miss still pending here is picked up again from RUN
                pc_en      = 1'b0;
                ifid_hold  = 1'b1;
                exmem_hold = 1'b1;
                next_state = RUN;
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    always_comb begin
        pc_enable_o   = rst_i & pc_en;
        ifid_hold_o   = rst_i & ifid_hold;
        ifid_flush_o  = rst_i & ifid_flush;
        idex_bubble_o = rst_i & idex_bubble;
        exmem_hold_o  = rst_i & exmem_hold;
        imem_req_o    = rst_i & imem_req;
        dmem_req_o    = rst_i & dmem_req;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else if (clr_cnt_i) begin
            cnt <= '0;
        end else if (!pc_en && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign state_o     = state;
    assign stall_cnt_o = cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected outputs are queued at
// drive time and compared mid-cycle with immediate assertions.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CW = 4;

    // {pc_en, ifid_hold, ifid_flush, idex_bubble, exmem_hold, imem_req, dmem_req}
    localparam logic [6:0] O_RUN   = 7'b1000000;
    localparam logic [6:0] O_LU    = 7'b0101000;
    localparam logic [6:0] O_BR    = 7'b1010000;
    localparam logic [6:0] O_IMISS = 7'b0010000;
    localparam logic [6:0] O_IW    = 7'b0010010;
    localparam logic [6:0] O_IWD   = 7'b0010110;
    localparam logic [6:0] O_DMISS = 7'b0100100;
    localparam logic [6:0] O_DW    = 7'b0100101;
    localparam logic [6:0] O_DRAIN = 7'b0100100;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          ex_memread, branch_taken, imem_miss, dmem_miss;
    logic          imem_ack, dmem_ack, clr_cnt;
    logic          pc_enable, ifid_hold, ifid_flush, idex_bubble, exmem_hold;
    logic          imem_req, dmem_req;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt;

    typedef struct packed {
        logic [6:0]    outs;
        logic [1:0]    st;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    logic [CW-1:0] model_cnt;
    int            n_checks;
    int            n_fails;

    pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .ex_rt_i(ex_rt),
        .ex_memread_i(ex_memread), .branch_taken_i(branch_taken),
        .imem_miss_i(imem_miss), .dmem_miss_i(dmem_miss),
        .imem_ack_i(imem_ack), .dmem_ack_i(dmem_ack), .clr_cnt_i(clr_cnt),
        .pc_enable_o(pc_enable), .ifid_hold_o(ifid_hold), .ifid_flush_o(ifid_flush),
        .idex_bubble_o(idex_bubble), .exmem_hold_o(exmem_hold),
        .imem_req_o(imem_req), .dmem_req_o(dmem_req),
        .state_o(state), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs_now();
        return {pc_enable, ifid_hold, ifid_flush, idex_bubble, exmem_hold, imem_req, dmem_req};
    endfunction

    task automatic idle();
        id_rs = '0; id_rt = '0; ex_rt = '0; ex_memread = 1'b0;
        branch_taken = 1'b0; imem_miss = 1'b0; dmem_miss = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic chk_outs(input string tag, input logic [6:0] exp_o);
        n_checks++;
        assert (outs_now() === exp_o) else begin
            n_fails++;
            $error("FAIL %s outs: observed %b expected %b", tag, outs_now(), exp_o);
        end
    endtask

    task automatic chk_state(input string tag, input logic [1:0] exp_s);
        n_checks++;
        assert (state === exp_s) else begin
            n_fails++;
            $error("FAIL %s state: observed %0d expected %0d", tag, state, exp_s);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [CW-1:0] exp_c);
        n_checks++;
        assert (stall_cnt === exp_c) else begin
            n_fails++;
            $error("FAIL %s cnt: observed %0d expected %0d", tag, stall_cnt, exp_c);
        end
    endtask

    // Inputs are already driven; queue the expectation, compare at negedge,
    // then advance the counter model across the rising edge.
    task automatic step(input string tag, input logic [6:0] exp_o, input logic [1:0] exp_s);
        exp_t e;
        sb.push_back('{outs: exp_o, st: exp_s, cnt: model_cnt});
        @(negedge clk);
        e = sb.pop_front();
        chk_outs(tag, e.outs);
        chk_state(tag, e.st);
        chk_cnt(tag, e.cnt);
        @(posedge clk);
        if (clr_cnt) model_cnt = '0;
        else if (!exp_o[6] && model_cnt != '1) model_cnt = model_cnt + 1'b1;
        #1;
        idle();
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        model_cnt = '0;
        rst_i     = 1'b0;
        idle();
        #1;
        chk_outs("reset", 7'b0000000);
        chk_state("reset", 2'd0);
        chk_cnt("reset", '0);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;

        step("idle", O_RUN, 2'd0);

        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        step("lu_rs", O_LU, 2'd0);
        step("after_lu", O_RUN, 2'd0);
        n_checks++;
        assert (stall_cnt === 4'd1) else begin
            n_fails++;
            $error("FAIL lu_cnt: observed %0d expected 1", stall_cnt);
        end

        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        step("r0_no_stall", O_RUN, 2'd0);
        ex_memread = 1'b1; ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
        step("lu_rt", O_LU, 2'd0);
        ex_memread = 1'b0; ex_rt = 5'd7; id_rt = 5'd7;
        step("no_load", O_RUN, 2'd0);

        imem_miss = 1'b1; branch_taken = 1'b1;
        step("br_over_imiss", O_BR, 2'd0);
        ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; branch_taken = 1'b1;
        step("lu_over_br", O_LU, 2'd0);
        imem_ack = 1'b1; dmem_ack = 1'b1;
        step("stray_ack_run", O_RUN, 2'd0);

        // I-miss, ack on the fourth IWAIT cycle
        imem_miss = 1'b1;
        step("imiss", O_IMISS, 2'd0);
        step("iwait1", O_IW, 2'd1);
        dmem_ack = 1'b1;
        step("iwait2_dack", O_IW, 2'd1);
        step("iwait3", O_IW, 2'd1);
        imem_ack = 1'b1;
        step("iwait4_ack", O_IW, 2'd1);
        step("drain", O_DRAIN, 2'd3);
        step("run_after", O_RUN, 2'd0);

        // D-miss raised during IWAIT is serviced after the I-refill
        imem_miss = 1'b1;
        step("imiss2", O_IMISS, 2'd0);
        dmem_miss = 1'b1;
        step("iwait_dmiss", O_IWD, 2'd1);
        dmem_miss = 1'b1; imem_ack = 1'b1;
        step("iwait_dmiss_ack", O_IWD, 2'd1);
        dmem_miss = 1'b1;
        step("drain2", O_DRAIN, 2'd3);
        dmem_miss = 1'b1;
        step("run_dmiss", O_DMISS, 2'd0);
        imem_ack = 1'b1;
        step("dwait_iack", O_DW, 2'd2);
        step("dwait", O_DW, 2'd2);

        // asynchronous reset in DWAIT
        #2;
        rst_i = 1'b0;
        #1;
        chk_outs("rst_dwait", 7'b0000000);
        chk_state("rst_dwait", 2'd0);
        chk_cnt("rst_dwait", '0);
        model_cnt = '0;
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        step("post_rst", O_RUN, 2'd0);

        // full priority stack in RUN: D-miss wins
        dmem_miss = 1'b1; imem_miss = 1'b1; branch_taken = 1'b1;
        ex_memread = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
        step("prio_dmiss", O_DMISS, 2'd0);
        dmem_ack = 1'b1;
        step("dwait_ack", O_DW, 2'd2);
        step("drain3", O_DRAIN, 2'd3);
        step("run3", O_RUN, 2'd0);

        // saturation then clear during a stall
        for (int i = 0; i < 20; i++) begin
            ex_memread = 1'b1; ex_rt = 5'd6; id_rs = 5'd6;
            step("sat_lu", O_LU, 2'd0);
        end
        @(negedge clk);
        n_checks++;
        assert (stall_cnt === 4'hF) else begin
            n_fails++;
            $error("FAIL sat_cnt: observed %0d expected 15", stall_cnt);
        end
        @(posedge clk);
        #1;
        ex_memread = 1'b1; ex_rt = 5'd6; id_rs = 5'd6; clr_cnt = 1'b1;
        step("clr_in_stall", O_LU, 2'd0);
        step("after_clr", O_RUN, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
